// File: rtl/mem_xfer_ctrl.sv
// Copies DEPTH bytes from a registered-read source memory to a destination memory,
// passing host load accesses through to the source while idle.
module mem_xfer_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    host_addr,
  input  logic             host_we,
  input  logic [DW-1:0]    host_data,
  output logic [AW-1:0]    AddrA,
  output logic             WEA,
  output logic [DW-1:0]    DataInA,
  input  logic [DW-1:0]    DOut1,
  output logic [AW-1:0]    AddrB,
  output logic             WEB,
  output logic [DW-1:0]    DataInB,
  output logic             busy,
  output logic             done,
  output logic [DW+AW-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e            state_q;
  logic [AW-1:0]     rd_addr_q;
  logic [AW-1:0]     wr_addr_q;
  logic              wr_pend_q;
  logic [DW+AW-1:0]  checksum_q;
  logic [DW+AW-1:0]  checksum_d;
  logic              busy_q;
  logic              done_q;

  assign checksum_d = checksum_q + (DW+AW)'(DOut1);

  // The destination write trails the source read by one cycle, covering the read latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_pend_q  <= 1'b0;
      checksum_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_pend_q) checksum_q <= checksum_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= RUN;
            rd_addr_q  <= '0;
            checksum_q <= '0;
            wr_pend_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          wr_addr_q <= rd_addr_q;
          wr_pend_q <= 1'b1;
          if (rd_addr_q == LAST) begin
            state_q <= FLUSH;
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
        FLUSH: begin
          wr_pend_q <= 1'b0;
          state_q   <= DONE;
          done_q    <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Host owns the source port only while idle; the transfer never writes the source.
  always_comb begin
    AddrA   = rd_addr_q;
    WEA     = 1'b0;
    DataInA = '0;
    if (state_q == IDLE) begin
      AddrA   = host_addr;
      WEA     = host_we;
      DataInA = host_data;
    end
  end

  assign AddrB    = wr_addr_q;
  assign WEB      = wr_pend_q;
  assign DataInB  = DOut1;
  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = checksum_q;

endmodule

// File: doc/mem_xfer_ctrl.md
Name: mem_xfer_ctrl

Overview:
- Transfer controller that sits directly downstream of the 8x8 source memory (memoryA).
- While idle, it passes host load accesses through to the source memory.
- On `start`, it reads all source locations in order and writes each byte to the same address of the destination memory, with a pipelined one-cycle read latency.
- Reports `busy`/`done` and a running byte sum of the transferred data.

Parameters:
- DW, 8, data width in bits.
- AW, 3, address width in bits.
- DEPTH, 8, locations to transfer (addresses 0..DEPTH-1; DEPTH <= 2^AW).

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  transfer request, sampled only in IDLE.
- host_addr  input  AW  host load address for the source memory.
- host_we  input  1  host load write enable.
- host_data  input  DW  host load data.
- AddrA  output  AW  source memory address.
- WEA  output  1  source memory write enable.
- DataInA  output  DW  source memory write data.
- DOut1  input  DW  source memory registered read data (valid one clock after the address is presented with WEA=0).
- AddrB  output  AW  destination memory address.
- WEB  output  1  destination memory write enable.
- DataInB  output  DW  destination memory write data.
- busy  output  1  high from the cycle after `start` is accepted until DONE is left.
- done  output  1  one-cycle pulse when the transfer completes.
- checksum  output  DW+AW  unsigned sum of all bytes written to the destination in the current or last transfer.

Behaviour:
- **States:** IDLE, RUN, FLUSH, DONE. Reset (async) forces IDLE.
- **Registered internals:** `rd_addr` (AW), `wr_addr` (AW), `wr_pend` (1), `checksum`, state. All clear to 0 on reset.

Reset output values:
- In IDLE, AddrA/WEA/DataInA follow the host inputs.
- WEB=0, AddrB=0, busy=0, done=0, checksum=0.

IDLE:
- AddrA=host_addr, WEA=host_we, DataInA=host_data (combinational mux).
- `start`=1 at a clock edge causes:
  - state->RUN
  - rd_addr<=0
  - checksum<=0
  - wr_pend<=0

RUN:
- AddrA=rd_addr, WEA=0, DataInA=0. Host inputs are ignored.
- Each edge performs three updates:
  - wr_addr<=rd_addr
  - wr_pend<=1
  - rd_addr<=rd_addr+1
- When rd_addr==DEPTH-1: state->FLUSH and rd_addr holds.

FLUSH:
- AddrA=rd_addr, WEA=0.
- Completes the final pending write; wr_pend<=0; state->DONE.

DONE:
- done=1 for exactly this cycle; state->IDLE next edge.

Destination side (all states):
- WEB=wr_pend, AddrB=wr_addr, DataInB=DOut1.
- On every edge where WEB=1: checksum<=checksum+DataInB (zero-extended). No overflow is possible for DEPTH<=8, DW=8 (max 2040 < 2^11).

Busy and latency:
- busy=1 in RUN, FLUSH and DONE.
- `start` asserted outside IDLE is ignored; it is not queued.
- Latency: `start` accepted at edge E0.
  - Destination writes occur at edges E2..E(DEPTH+1), addresses 0..DEPTH-1 in order.
  - done is high during cycle E(DEPTH+1)..E(DEPTH+2).
  - busy is high for DEPTH+2 cycles.
- Exactly DEPTH destination writes per transfer, with no gaps or duplicates.

Reset mid-transfer:
- WEB drops to 0 immediately (async) and the state machine returns to IDLE.
- Checksum is cleared; destination contents are left partially written.

Boundary cases:
- `start` and host_we both high in IDLE on the same edge: the host write to the source memory completes on that edge, and the transfer starts.
- Back-to-back `start` held high continuously: a new transfer begins on the first edge after returning to IDLE.
- DEPTH=1: RUN lasts one cycle; exactly one write, to address 0.

Test Plan:
1. Host loads source addresses 0..7 with 8'h10..8'h17, then pulses `start` -> destination address i holds 8'h10+i, WEB high for exactly 8 consecutive cycles, done single pulse 10 cycles after `start` accepted, checksum=11'd156.
2. Source all 8'hFF, `start` -> checksum=11'd2040, all destination bytes 8'hFF, no overflow.
3. Pulse `start` again mid-transfer (cycle 4) -> ignored; exactly 8 writes; done pulses once; host_we=1 during RUN does not alter the source memory (WEA=0 throughout).
4. Assert reset at cycle 5 of a transfer -> WEB=0, busy=0, checksum=0 asynchronously; destination addresses 0..3 written, 4..7 unchanged; a subsequent `start` completes normally.
5. Hold `start` high for 30 cycles -> two complete transfers separated by a single IDLE cycle; busy low only in that cycle.
6. `start` and host_we (addr 3, 8'hAA) asserted on the same edge -> the transfer copies 8'hAA to destination address 3.
